ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain loader for the eFPGA fabric. Accepts the bitstream as WORD_W-bit words over a valid/ready handshake and serialises them onto a connection/switch-block `ccff_head` chain, one bit per `prog_clk` cycle, with a per-bit shift enable. It sits between the bitstream source (SPI/Wishbone bridge) and the head of the tile configuration-flop chain. It sequences a complete load of CHAIN_LEN bits and reports completion.

## Interface
Parameters:
- CHAIN_LEN, 42, total configuration flops in the chain (7 size-8 mux memories × 6 bits); ≥ 1
- WORD_W, 32, bitstream word width; ≥ 16
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width

Ports:
- prog_clk  in  1  configuration clock; single clock domain
- pReset  in  1  synchronous, active-low reset
- start  in  1  one-cycle load request; honoured only in IDLE
- word_data  in  WORD_W  bitstream word; bit 0 is shifted first
- word_valid  in  1  word_data valid
- word_ready  out  1  loader accepts word this cycle
- ccff_head  out  1  serial bit into the chain head
- ccff_shift_en  out  1  chain flops capture `ccff_head` this cycle
- busy  out  1  load in progress (not IDLE)
- done  out  1  one-cycle pulse when load completes
- bits_left  out  CNT_W  chain bits still to shift
- crc_err  out  1  CRC mismatch on last load (CRC build only)

## Operation
- States: IDLE, LOAD, SHIFT, CHECK (CRC build only), DONE.
- IDLE: `start` → LOAD, bits_left ← CHAIN_LEN, crc_err ← 0. `start` in any other state is ignored.
- LOAD: word_ready=1. On word_valid&&word_ready, the loader latches the word into the shift register, captures n = min(WORD_W, bits_left), and moves to SHIFT.
- SHIFT: ccff_shift_en=1; ccff_head = shreg[0]; each cycle shreg >>= 1 and bits_left decrements. After n cycles: bits_left≠0 → LOAD; bits_left=0 → CHECK (CRC build) or DONE.
- Final word: bits above position n-1 are discarded and never shifted.
- Bit ordering: the first bit shifted ends at the far (ccff_tail) end of the chain after CHAIN_LEN shifts.
- DONE: done=1 for one cycle, then IDLE.
- word_valid outside LOAD has no effect, because word_ready=0.
- Reset mid-load: outputs take their reset values on the next edge. Chain contents are left partial; software reissues `start`.

## Timing
- Reset values: word_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, bits_left=0, crc_err=0; state=IDLE.
- All outputs are registered.
- Cycle numbering, with `start` sampled at edge 0: LOAD at cycle 1. With word_valid held high, each word costs 1 accept cycle plus n shift cycles.
- Defaults (42/32), non-CRC build: shifts occupy cycles 2–33 and 35–44; done at cycle 45.
- A word_valid stall holds the loader in LOAD; ccff_shift_en stays 0 and no bit is lost.
- ccff_shift_en and ccff_head change together on the same edge. The chain samples them on the following edge.

## Configuration
- Macro: CCFF_LOADER_CRC_EN.
- Defined:
  - Bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first register) runs over every shifted bit, in shift order.
  - After the last data shift, the loader enters CHECK with word_ready=1 and accepts one extra word; word_data[15:0] is the expected CRC.
  - Mismatch sets crc_err=1, held until the next `start`. DONE follows in either case.
  - Default-parameter timing: done at cycle 47 (CHECK accept at 45, DONE register at 46, pulse visible 47 as registered).
- Undefined: no CHECK state, no CRC logic, crc_err tied 0.

## Structure
- Package `ccff_loader_pkg`: state enum, CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF.
- Sub-module `ccff_crc16_serial`: clear, bit-enable, data bit in, 16-bit CRC out. Instantiated only under CCFF_LOADER_CRC_EN.

## Test plan
- Defaults, start, two words 0xA5A5_0F0F and 0x0000_03C3, valid always high → 42 shifts. Bit stream: 0xA5A50F0F LSB-first, then 10 bits of 0x3C3. done at cycle 45 (non-CRC); bits_left=0.
- word_valid deasserted 5 cycles before the second word → ccff_shift_en low for those 5 cycles, no dropped bits, done delayed by 5.
- start asserted during SHIFT, and word_valid asserted in IDLE → both ignored; bit sequence and word_ready unchanged.
- pReset low at the 10th shift → next edge: ccff_shift_en=0, busy=0, bits_left=0; a new start loads cleanly.
- CHAIN_LEN=32, single word 0xFFFFFFFF → exactly 32 shifts, one word accepted, done pulse of one cycle.
- CRC build: correct CRC word → crc_err=0; CRC word with one bit flipped → crc_err=1, held until the next start.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared definitions for the configuration-chain loader.
//   - ccff_state_e : loader FSM states
//   - CRC16_POLY / CRC16_INIT : CRC-16-CCITT constants for the optional
//     bitstream check (build macro CCFF_LOADER_CRC_EN)
//   - crc16_step   : one bit-serial, MSB-first CRC update
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } ccff_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Feedback is the register MSB xor the incoming bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// ccff_crc16_serial: bit-serial CRC-16-CCITT accumulator.
// Ports:
//   clk     in   clock
//   rst_n   in   synchronous active-low reset (register returns to init)
//   clear   in   reload CRC16_INIT (priority over bit_en)
//   bit_en  in   fold bit_in into the CRC this cycle
//   bit_in  in   serial data bit
//   crc     out  current CRC register
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      crc <= CRC16_INIT;
    end else if (bit_en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: takes bitstream words over valid/ready and serialises
// CHAIN_LEN bits, LSB of each word first, onto the ccff_head chain input with
// a per-bit shift enable, then pulses done.
// Build macro CCFF_LOADER_CRC_EN adds a CHECK state that accepts one extra
// word whose [15:0] is compared with a CRC-16-CCITT of the shifted bits;
// without it crc_err is tied low.
// Ports:
//   prog_clk       in   configuration clock
//   pReset         in   synchronous active-low reset
//   start          in   load request, honoured only while idle
//   word_data      in   bitstream word, bit 0 shifted first
//   word_valid     in   word_data valid
//   word_ready     out  word accepted this cycle when valid
//   ccff_head      out  serial bit into the chain head
//   ccff_shift_en  out  chain captures ccff_head this cycle
//   busy           out  load in progress
//   done           out  one-cycle completion pulse
//   bits_left      out  chain bits still to shift
//   crc_err        out  CRC mismatch on last load
// All outputs are registered from the next-state decode.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 42,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_left,
  output logic              crc_err
);

  localparam int WC_W = $clog2(WORD_W + 1);

  ccff_state_e       state_q, state_d;
  logic [CNT_W-1:0]  bits_left_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [WC_W-1:0]   n_word;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              head_d;
  logic              ready_d;

`ifdef CCFF_LOADER_CRC_EN
  logic              crc_clr, crc_en;
  logic [15:0]       crc_val;
  logic [15:0]       exp_q, exp_d;
  logic              chk_cmp_q, chk_cmp_d;
  logic              crc_err_q, crc_err_d;

  ccff_crc16_serial u_crc (
    .clk    (prog_clk),
    .rst_n  (pReset),
    .clear  (crc_clr),
    .bit_en (crc_en),
    .bit_in (shreg_q[0]),
    .crc    (crc_val)
  );

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  // Bits taken from the word being accepted: the final word is truncated.
  always_comb begin
    n_word = WC_W'(WORD_W);
    if (int'(bits_left) < WORD_W) n_word = WC_W'(bits_left);
  end

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left;
    wcnt_d      = wcnt_q;
    shreg_d     = shreg_q;
    head_d      = 1'b0;
    ready_d     = 1'b0;
`ifdef CCFF_LOADER_CRC_EN
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    exp_d       = exp_q;
    chk_cmp_d   = chk_cmp_q;
    crc_err_d   = crc_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          bits_left_d = CNT_W'(CHAIN_LEN);
`ifdef CCFF_LOADER_CRC_EN
          crc_clr     = 1'b1;
          crc_err_d   = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (word_valid && word_ready) begin
          shreg_d = word_data;
          wcnt_d  = n_word;
          head_d  = word_data[0];
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Rotate rather than zero-fill: the wrapped bit is never shifted out.
        shreg_d     = {shreg_q[0], shreg_q[WORD_W-1:1]};
        bits_left_d = bits_left - CNT_W'(1);
        wcnt_d      = wcnt_q - WC_W'(1);
`ifdef CCFF_LOADER_CRC_EN
        crc_en      = 1'b1;
`endif
        if (wcnt_q == WC_W'(1)) begin
          if (bits_left == CNT_W'(1)) begin
`ifdef CCFF_LOADER_CRC_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          head_d = shreg_q[1];
        end
      end
`ifdef CCFF_LOADER_CRC_EN
      // First phase accepts the CRC word, second phase compares it.
      ST_CHECK: begin
        if (!chk_cmp_q) begin
          if (word_valid && word_ready) begin
            exp_d     = word_data[15:0];
            chk_cmp_d = 1'b1;
          end
        end else begin
          crc_err_d = (exp_q != crc_val);
          chk_cmp_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_LOAD);
`ifdef CCFF_LOADER_CRC_EN
    if (state_d == ST_CHECK && !chk_cmp_d) ready_d = 1'b1;
`endif
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state_q       <= ST_IDLE;
      bits_left     <= '0;
      wcnt_q        <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      word_ready    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef CCFF_LOADER_CRC_EN
      chk_cmp_q     <= 1'b0;
      crc_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bits_left     <= bits_left_d;
      wcnt_q        <= wcnt_d;
      ccff_head     <= head_d;
      ccff_shift_en <= (state_d == ST_SHIFT);
      word_ready    <= ready_d;
      busy          <= (state_d != ST_IDLE);
      done          <= (state_d == ST_DONE);
`ifdef CCFF_LOADER_CRC_EN
      chk_cmp_q     <= chk_cmp_d;
      crc_err_q     <= crc_err_d;
`endif
    end
  end

  // Data registers carry no reset; they are always reloaded before use.
  always_ff @(posedge prog_clk) begin
    shreg_q <= shreg_d;
`ifdef CCFF_LOADER_CRC_EN
    exp_q   <= exp_d;
`endif
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

  localparam int CL  = 42;
  localparam int W   = 32;
  localparam int CW  = $clog2(CL + 1);
  localparam int CL2 = 32;
  localparam int CW2 = $clog2(CL2 + 1);
`ifdef CCFF_LOADER_CRC_EN
  localparam int DONE1 = 47;
  localparam int DONE2 = 36;
  localparam int ACC2  = 2;
`else
  localparam int DONE1 = 45;
  localparam int DONE2 = 34;
  localparam int ACC2  = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, word_valid, word_ready;
  logic          ccff_head, ccff_shift_en, busy, done, crc_err;
  logic [W-1:0]  word_data;
  logic [CW-1:0] bits_left;

  logic           start2, valid2, ready2, head2, shift2, busy2, done2, crc_err2;
  logic [W-1:0]   data2;
  logic [CW2-1:0] bits_left2;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
    .prog_clk(clk), .pReset(rst_n), .start(start), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .busy(busy), .done(done),
    .bits_left(bits_left), .crc_err(crc_err)
  );

  ccff_chain_loader #(.CHAIN_LEN(CL2), .WORD_W(W)) dut2 (
    .prog_clk(clk), .pReset(rst_n), .start(start2), .word_data(data2),
    .word_valid(valid2), .word_ready(ready2), .ccff_head(head2),
    .ccff_shift_en(shift2), .busy(busy2), .done(done2),
    .bits_left(bits_left2), .crc_err(crc_err2)
  );

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int acc_cnt = 0;
  bit cmp_on = 1'b0;

  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (word_valid && word_ready) acc_cnt <= acc_cnt + 1;
  end

  // Reference model: a queue of bits still owed to the chain for the word
  // in flight, plus the few flags the outputs are defined by.
  bit   mq[$];
  bit   m_active = 1'b0, m_ready = 1'b0, m_done = 1'b0;
  int   m_left = 0;
  logic m_crc_err = 1'b0;
`ifdef CCFF_LOADER_CRC_EN
  logic [15:0] m_crc = 16'hFFFF, m_exp = 16'h0;
  bit          m_in_check = 1'b0, m_cmp = 1'b0;
`endif

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    c = {c[14:0], 1'b0};
    if (fb) c = c ^ 16'h1021;
    return c;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0; m_ready = 1'b0; m_done = 1'b0; m_left = 0; m_crc_err = 1'b0;
`ifdef CCFF_LOADER_CRC_EN
      m_in_check = 1'b0; m_cmp = 1'b0;
`endif
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_ready = 1'b1; m_left = CL; m_crc_err = 1'b0;
`ifdef CCFF_LOADER_CRC_EN
        m_crc = 16'hFFFF;
`endif
      end
    end else if (m_done) begin
      m_done = 1'b0; m_active = 1'b0;
    end else if (mq.size() > 0) begin
`ifdef CCFF_LOADER_CRC_EN
      m_crc = crc_bit(m_crc, mq[0]);
`endif
      void'(mq.pop_front());
      m_left = m_left - 1;
      if (mq.size() == 0) begin
        if (m_left > 0) m_ready = 1'b1;
        else begin
`ifdef CCFF_LOADER_CRC_EN
          m_ready = 1'b1; m_in_check = 1'b1;
`else
          m_done = 1'b1;
`endif
        end
      end
`ifdef CCFF_LOADER_CRC_EN
    end else if (m_cmp) begin
      m_cmp = 1'b0; m_crc_err = (m_exp != m_crc); m_done = 1'b1;
    end else if (m_ready && word_valid && m_in_check) begin
      m_ready = 1'b0; m_in_check = 1'b0; m_cmp = 1'b1; m_exp = word_data[15:0];
`endif
    end else if (m_ready && word_valid) begin
      m_ready = 1'b0;
      for (int i = 0; i < ((m_left < W) ? m_left : W); i++) mq.push_back(word_data[i]);
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("word_ready", 64'(word_ready), 64'(m_ready));
    check("shift_en", 64'(ccff_shift_en), 64'(mq.size() > 0));
    check("head", 64'(ccff_head), 64'((mq.size() > 0) ? mq[0] : 1'b0));
    check("busy", 64'(busy), 64'(m_active));
    check("done", 64'(done), 64'(m_done));
    check("bits_left", 64'(bits_left), 64'(m_left));
    check("crc_err", 64'(crc_err), 64'(m_crc_err));
  endtask

  task automatic tick();
    @(negedge clk);
    if (cmp_on) compare();
  endtask

  logic [W-1:0]  wq[$];
  logic          slog[$];
  logic [CL-1:0] got;

  function automatic logic [CL-1:0] exp_stream();
    logic [CL-1:0] v;
    logic [W-1:0]  w;
    v = '0;
    for (int i = 0; i < CL; i++) begin
      w = wq[i / W];
      v[i] = w[i % W];
    end
    return v;
  endfunction

  function automatic logic [15:0] stream_crc(input logic [CL-1:0] v);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < CL; i++) c = crc_bit(c, v[i]);
    return c;
  endfunction

  task automatic set_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [15:0] flip);
    wq.delete();
    wq.push_back(w0);
    wq.push_back(w1);
`ifdef CCFF_LOADER_CRC_EN
    wq.push_back({16'h0, stream_crc(exp_stream()) ^ flip});
`else
    if (flip != 16'h0) wq.push_back(W'(flip));
`endif
  endtask

  task automatic check_stream(input string nm);
    logic [CL-1:0] g;
    g = '0;
    for (int i = 0; i < slog.size() && i < CL; i++) g[i] = slog[i];
    check({nm, "_len"}, 64'(slog.size()), 64'(CL));
    check({nm, "_bits"}, 64'(g), 64'(exp_stream()));
    got = g;
  endtask

  task automatic run_load(input int stall_lo, input int stall_hi, input int start_mid,
                          input int pct, output int done_cyc,
                          output logic [CW-1:0] bl_done, output logic err_done);
    int base, s0, cyc, idx;
    base = acc_cnt;
    slog.delete();
    done_cyc = -1; bl_done = '0; err_done = 1'b0;
    start = 1'b1; word_valid = 1'b0;
    tick();
    s0 = ecnt;
    for (int t = 0; t < 600; t++) begin
      cyc = ecnt - s0 + 1;
      if (ccff_shift_en) slog.push_back(ccff_head);
      if (done) begin
        done_cyc = cyc; bl_done = bits_left; err_done = crc_err;
        break;
      end
      idx = acc_cnt - base;
      start = (cyc == start_mid);
      word_valid = (idx < int'(wq.size())) && !(cyc >= stall_lo && cyc <= stall_hi)
                   && (int'($urandom_range(0, 99)) < pct);
      word_data = (idx < int'(wq.size())) ? wq[idx] : W'($urandom);
      tick();
    end
    start = 1'b0; word_valid = 1'b0;
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
  endtask

  initial begin
    int dc, n, sh2, ones2, acc2, dn2, dcyc2;
    logic [CW-1:0] bl;
    logic er;
    rst_n = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0;
    start2 = 1'b0; valid2 = 1'b0; data2 = '0;
    repeat (3) tick();
    cmp_on = 1'b1;
    check("rst_word_ready", 64'(word_ready), 64'd0);
    check("rst_shift_en", 64'(ccff_shift_en), 64'd0);
    check("rst_head", 64'(ccff_head), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bits_left", 64'(bits_left), 64'd0);
    check("rst_crc_err", 64'(crc_err), 64'd0);
    rst_n = 1'b1;

    // word_valid while idle must not be taken
    word_valid = 1'b1; word_data = 32'hDEADBEEF;
    repeat (4) tick();
    check("idle_accepts", 64'(acc_cnt), 64'd0);
    word_valid = 1'b0;
    tick();

    // directed load, stray start in the middle
    set_words(32'hA5A50F0F, 32'h000003C3, 16'h0);
    run_load(-1, -1, 10, 100, dc, bl, er);
    check("t1_done_cycle", 64'(dc), 64'(DONE1));
    check("t1_bits_left", 64'(bl), 64'd0);
    check("t1_crc_err", 64'(er), 64'd0);
    check_stream("t1");
    check("t1_literal", 64'(got), 64'h3C3A5A50F0F);
    repeat (3) tick();

    // five-cycle stall ahead of the second word
    run_load(34, 38, -1, 100, dc, bl, er);
    check("t2_done_cycle", 64'(dc), 64'(DONE1 + 5));
    check_stream("t2");
    check("t2_literal", 64'(got), 64'h3C3A5A50F0F);
    repeat (2) tick();

    // reset during the tenth shift
    set_words($urandom, $urandom, 16'h0);
    start = 1'b1; word_valid = 1'b1; word_data = wq[0];
    tick();
    start = 1'b0;
    n = 0;
    for (int t = 0; t < 60 && n < 10; t++) begin
      tick();
      if (ccff_shift_en) n++;
    end
    check("rst_mid_shifts", 64'(n), 64'd10);
    rst_n = 1'b0; word_valid = 1'b0;
    tick();
    check("rst_mid_shift_en", 64'(ccff_shift_en), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_bits_left", 64'(bits_left), 64'd0);
    check("rst_mid_ready", 64'(word_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    set_words($urandom, $urandom, 16'h0);
    run_load(-1, -1, -1, 100, dc, bl, er);
    check("t3_done_cycle", 64'(dc), 64'(DONE1));
    check_stream("t3");

    // randomized loads
    for (int k = 0; k < 6; k++) begin
      set_words($urandom, $urandom, 16'h0);
      run_load(-1, -1, int'($urandom_range(3, 40)), int'($urandom_range(40, 100)), dc, bl, er);
      check("rnd_bits_left", 64'(bl), 64'd0);
      check_stream("rnd");
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) begin
        word_valid = 1'($urandom_range(0, 1));
        word_data = $urandom;
        tick();
      end
      word_valid = 1'b0;
    end

`ifdef CCFF_LOADER_CRC_EN
    set_words(32'hA5A50F0F, 32'h000003C3, 16'h0010);
    run_load(-1, -1, -1, 100, dc, bl, er);
    check("crc_bad", 64'(er), 64'd1);
    repeat (5) tick();
    check("crc_bad_held", 64'(crc_err), 64'd1);
    set_words(32'hA5A50F0F, 32'h000003C3, 16'h0);
    run_load(-1, -1, -1, 100, dc, bl, er);
    check("crc_good", 64'(er), 64'd0);
    tick();
`endif

    // CHAIN_LEN=32, single all-ones word
    sh2 = 0; ones2 = 0; acc2 = 0; dn2 = 0; dcyc2 = -1;
    start2 = 1'b1; valid2 = 1'b1; data2 = 32'hFFFFFFFF;
    tick();
    start2 = 1'b0;
    for (int c = 1; c < 100; c++) begin
      if (shift2) begin sh2++; if (head2) ones2++; end
      if (ready2 && valid2) acc2++;
      if (done2) begin
        dn2++;
        if (dcyc2 < 0) begin
          dcyc2 = c;
          check("c32_bits_left", 64'(bits_left2), 64'd0);
        end
      end
      if (dcyc2 >= 0 && c > dcyc2 + 3) break;
      tick();
    end
    valid2 = 1'b0;
    check("c32_shifts", 64'(sh2), 64'd32);
    check("c32_ones", 64'(ones2), 64'd32);
    check("c32_accepts", 64'(acc2), 64'(ACC2));
    check("c32_done_pulses", 64'(dn2), 64'd1);
    check("c32_done_cycle", 64'(dcyc2), 64'(DONE2));
    check("c32_busy_after", 64'(busy2), 64'd0);
`ifndef CCFF_LOADER_CRC_EN
    check("c32_crc_err", 64'(crc_err2), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
